// File: rtl/fp_sched_pkg.sv
// rtl/fp_sched_pkg.sv - shared types and widths for the fp add/sub arbiter
package fp_sched_pkg;

  localparam int FP_W  = 32;
  localparam int CNT_W = 4;
  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter, combinational one-hot grant
module rr_arb2
  import fp_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic             last_i,
  output logic [N_REQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    // On contention, favour whichever requester was not served last.
    if (req_i == 2'b11) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

endmodule

// File: rtl/fp_addsub_arb.sv
// rtl/fp_addsub_arb.sv - shares one external fp add/sub core between two requesters
module fp_addsub_arb
  import fp_sched_pkg::*;
#(
  parameter int CORE_LAT = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req0_valid,
  input  logic            i_req0_mode,
  input  logic [FP_W-1:0] i_req0_a,
  input  logic [FP_W-1:0] i_req0_b,
  output logic            o_req0_ready,
  input  logic            i_req1_valid,
  input  logic            i_req1_mode,
  input  logic [FP_W-1:0] i_req1_a,
  input  logic [FP_W-1:0] i_req1_b,
  output logic            o_req1_ready,
  output logic            o_core_mode,
  output logic [FP_W-1:0] o_core_a,
  output logic [FP_W-1:0] o_core_b,
  input  logic [FP_W-1:0] i_core_result,
  output logic            o_rsp_valid,
  output logic            o_rsp_id,
  output logic [FP_W-1:0] o_rsp_result,
  input  logic            i_rsp_ready,
  output logic            o_busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [FP_W-1:0]    a_q, a_d;
  logic [FP_W-1:0]    b_q, b_d;
  logic               id_q, id_d;
  logic [FP_W-1:0]    result_q, result_d;
  logic               last_q, last_d;
  logic [N_REQ-1:0]   grant;

  rr_arb2 u_arb (
    .req_i   ({i_req1_valid, i_req0_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  // Readies are gated by reset so every output is low while reset is held.
  assign o_req0_ready = (state_q == ST_IDLE) && grant[0] && !i_rst;
  assign o_req1_ready = (state_q == ST_IDLE) && grant[1] && !i_rst;
  assign o_core_mode  = mode_q;
  assign o_core_a     = a_q;
  assign o_core_b     = b_q;
  assign o_rsp_valid  = (state_q == ST_RESP);
  assign o_rsp_id     = id_q;
  assign o_rsp_result = result_q;
  assign o_busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    result_d = result_q;
    last_d   = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          id_d    = grant[1];
          mode_d  = grant[1] ? i_req1_mode : i_req0_mode;
          a_d     = grant[1] ? i_req1_a : i_req0_a;
          b_d     = grant[1] ? i_req1_b : i_req0_b;
          cnt_d   = CNT_W'(CORE_LAT - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_d = i_core_result;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_arb.sv
// tb/tb_fp_addsub_arb.sv - directed self-checking bench for fp_addsub_arb
module tb_fp_addsub_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_mode, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_mode, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic        core_mode;
  logic [31:0] core_a, core_b, core_res;
  logic        rsp_valid, rsp_id, rsp_ready, busy;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_addsub_arb #(.CORE_LAT(2)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req0_valid  (req0_valid),
    .i_req0_mode   (req0_mode),
    .i_req0_a      (req0_a),
    .i_req0_b      (req0_b),
    .o_req0_ready  (req0_ready),
    .i_req1_valid  (req1_valid),
    .i_req1_mode   (req1_mode),
    .i_req1_a      (req1_a),
    .i_req1_b      (req1_b),
    .o_req1_ready  (req1_ready),
    .o_core_mode   (core_mode),
    .o_core_a      (core_a),
    .o_core_b      (core_b),
    .i_core_result (core_res),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_id      (rsp_id),
    .o_rsp_result  (rsp_result),
    .i_rsp_ready   (rsp_ready),
    .o_busy        (busy)
  );

  // Core stand-in: table of known single-precision results, one register stage.
  function automatic logic [31:0] fp_model(input logic m, input logic [31:0] a, input logic [31:0] b);
    if (!m && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if ( m && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
    if (!m && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if ( m && a == 32'h40800000 && b == 32'h3F800000) return 32'h40400000;
    if (!m && a == 32'h3FC00000 && b == 32'h3F000000) return 32'h40000000;
    if ( m && a == 32'h40200000 && b == 32'h3F000000) return 32'h40000000;
    return 32'hDEADBEEF;
  endfunction

  always_ff @(posedge clk) core_res <= fp_model(core_mode, core_a, core_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic m, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_mode = m; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic m, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_mode = m; req1_a = a; req1_b = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    set_req0(1'b1, 1'b0, 32'h3F800000, 32'h40000000);
    set_req1(1'b1, 1'b1, 32'h40400000, 32'h3F800000);
    #2;
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, busy, rsp_id, core_mode} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {req0_ready, req1_ready, rsp_valid, busy, rsp_id, core_mode});
    end
    checks++;
    if ({core_a, core_b, rsp_result} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {core_a, core_b, rsp_result});
    end
    tick();
    tick();
    set_req0(1'b0, 1'b0, 32'h0, 32'h0);
    set_req1(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    #1;
    checks++;
    if ({req1_ready, req0_ready, busy, rsp_valid} !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_valid: got %b expected 0000", {req1_ready, req0_ready, busy, rsp_valid});
    end
    tick();
  endtask

  task automatic test_single();
    set_req0(1'b1, 1'b0, 32'h3F800000, 32'h40000000);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    set_req0(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if ({busy, rsp_valid, core_a, core_b} !== {2'b10, 32'h3F800000, 32'h40000000}) begin
        errors++;
        $display("FAIL single_exec c%0d: got busy=%b vld=%b a=%h b=%h expected 1 0 3f800000 40000000", c, busy, rsp_valid, core_a, core_b);
      end
      tick();
    end
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'h40400000}) begin
      errors++;
      $display("FAIL single_rsp: got vld=%b id=%b res=%h expected 1 0 40400000", rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: got busy=%b vld=%b expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy;
    logic        exp_id;
    logic [31:0] exp_res;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    set_req0(1'b1, 1'b0, 32'h3F800000, 32'h40000000);
    set_req1(1'b1, 1'b1, 32'h40400000, 32'h3F800000);
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      exp_id  = ((c / 4) % 2) == 1;
      exp_rdy = (c % 4 != 0) ? 2'b00 : (exp_id ? 2'b10 : 2'b01);
      exp_res = exp_id ? 32'h40000000 : 32'h40400000;
      checks++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready c%0d: got %b expected %b", c, {req1_ready, req0_ready}, exp_rdy);
      end
      if (c % 4 == 3) begin
        checks++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, exp_id, exp_res}) begin
          errors++;
          $display("FAIL rr_rsp c%0d: got vld=%b id=%b res=%h expected 1 %b %h", c, rsp_valid, rsp_id, rsp_result, exp_id, exp_res);
        end
      end else begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL rr_rsp_low c%0d: got %b expected 0", c, rsp_valid);
        end
      end
      tick();
    end
    set_req0(1'b0, 1'b0, 32'h0, 32'h0);
    set_req1(1'b0, 1'b0, 32'h0, 32'h0);
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    set_req0(1'b1, 1'b0, 32'h40000000, 32'h40000000);
    set_req1(1'b1, 1'b1, 32'h40400000, 32'h3F800000);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    set_req0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready} !== {2'b10, 32'h40800000, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold k%0d: got vld=%b id=%b res=%h rdy=%b%b expected 1 0 40800000 00", k, rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if ({busy, rsp_valid, req1_ready, req0_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release: got %b expected 0010", {busy, rsp_valid, req1_ready, req0_ready});
    end
  endtask

  task automatic test_sub();
    tick();
    set_req1(1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if ({core_mode, core_a, core_b, busy, rsp_valid} !== {1'b1, 32'h40400000, 32'h3F800000, 2'b10}) begin
        errors++;
        $display("FAIL sub_core c%0d: got m=%b a=%h b=%h busy=%b vld=%b expected 1 40400000 3f800000 1 0", c, core_mode, core_a, core_b, busy, rsp_valid);
      end
      tick();
    end
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b11, 32'h40000000}) begin
      errors++;
      $display("FAIL sub_rsp: got vld=%b id=%b res=%h expected 1 1 40000000", rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_req0(1'b1, 1'b0, 32'h3FC00000, 32'h3F000000);
    tick();
    set_req0(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'h40000000}) begin
      errors++;
      $display("FAIL pre_rst_rsp: got vld=%b id=%b res=%h expected 1 0 40000000", rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    set_req1(1'b1, 1'b1, 32'h40200000, 32'h3F000000);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      errors++;
      $display("FAIL pre_rst_grant: got %b expected 10", {req1_ready, req0_ready});
    end
    tick();
    set_req1(1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, rsp_valid, core_mode, core_a, core_b, rsp_result} !== 99'h0) begin
      errors++;
      $display("FAIL async_rst: got busy=%b vld=%b m=%b a=%h b=%h res=%h expected all 0", busy, rsp_valid, core_mode, core_a, core_b, rsp_result);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL post_rst_quiet c%0d: got busy=%b vld=%b expected 0 0", c, busy, rsp_valid);
      end
      tick();
    end
    set_req0(1'b1, 1'b1, 32'h40800000, 32'h3F800000);
    set_req1(1'b1, 1'b1, 32'h40200000, 32'h3F000000);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL post_rst_grant: got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    set_req0(1'b0, 1'b0, 32'h0, 32'h0);
    set_req1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'h40400000}) begin
      errors++;
      $display("FAIL post_rst_rsp: got vld=%b id=%b res=%h expected 1 0 40400000", rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_sub();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arb.md
FP_ADDSUB_ARB -- requirements
Module: fp_addsub_arb

Interface
REQ-001 Parameter: CORE_LAT, default 2, meaning cycles from operand launch to valid i_core_result (legal 1..15).
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req0_valid  input  1  requester 0 has an operation pending.
REQ-005 i_req0_mode  input  1  requester 0 op: 0 add, 1 subtract.
REQ-006 i_req0_a, i_req0_b  input  32 each  requester 0 IEEE-754 single operands.
REQ-007 o_req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 i_req1_valid, i_req1_mode, i_req1_a, i_req1_b, o_req1_ready  same widths and meaning for requester 1.
REQ-009 o_core_mode  output  1; o_core_a, o_core_b  output  32 each  operands driven to the shared add/sub core.
REQ-010 i_core_result  input  32  core result, valid CORE_LAT cycles after launch.
REQ-011 o_rsp_valid  output  1  response available.
REQ-012 o_rsp_id  output  1  requester owning the response.
REQ-013 o_rsp_result  output  32  captured core result.
REQ-014 i_rsp_ready  input  1  response consumer accepts.
REQ-015 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP; exactly one operation in flight at a time.
REQ-017 IDLE: grant = round-robin over valid requesters; o_reqN_ready = (state==IDLE) && grantN, combinational, at most one high.
REQ-018 Both valid in IDLE -> grant the requester not granted last; single valid -> grant it regardless of history.
REQ-019 Handshake (valid && ready) -> capture mode, a, b, id into registers; load counter with CORE_LAT-1; next state EXEC.
REQ-020 IDLE with no valid -> remain IDLE; all ready outputs low.
REQ-021 o_core_mode/a/b driven from capture registers in all states; stable for the entire EXEC period.
REQ-022 EXEC: counter decrements each cycle; in the cycle counter==0, capture i_core_result into result register; next state RESP. EXEC lasts exactly CORE_LAT cycles.
REQ-023 RESP: o_rsp_valid=1; o_rsp_id, o_rsp_result held stable until i_rsp_ready.
REQ-024 RESP with i_rsp_ready -> next state IDLE; last-grant pointer updates to o_rsp_id at this transition.
REQ-025 Accept-to-response latency: handshake in cycle t -> o_rsp_valid first high in cycle t+CORE_LAT+1; minimum issue interval CORE_LAT+2 cycles.
REQ-026 Requester valid deasserted mid-operation has no effect; inputs sampled only at handshake.
REQ-027 o_rsp_valid low outside RESP; o_busy = (state != IDLE).

Reset
REQ-028 i_rst high -> state IDLE, counter 0, capture/result registers 0, last-grant pointer 1 (requester 0 favoured first), all outputs 0, immediately without a clock edge.
REQ-029 Reset during EXEC or RESP -> in-flight operation discarded; no response issued after release.
REQ-030 First rising edge after i_rst deasserts behaves as IDLE with requester 0 priority.

Structure
REQ-031 Shared package fp_sched_pkg holds: FSM state encoding, FP_W=32, counter width 4, requester count 2.
REQ-032 One sub-module rr_arb2: two-request round-robin arbiter (inputs: requests, last-grant; output: one-hot grant), combinational.
REQ-033 Core itself is external; this block contains no floating-point arithmetic.

Verification (CORE_LAT=2, core model returns a+b or a-b after 2 cycles)
REQ-034 req0 add a=0x3F800000, b=0x40000000 at cycle 0 -> ready0 cycle 0; rsp_valid cycle 3, id 0, result 0x40400000.
REQ-035 req0 and req1 valid together after reset -> req0 served first, req1 accepted the cycle after req0 response handshake; rsp ids 0 then 1.
REQ-036 Both held valid for 4 operations -> grant order 0,1,0,1; no starvation.
REQ-037 i_rsp_ready held low 5 cycles in RESP -> rsp_valid, id, result stable; ready0/ready1 low throughout; IDLE the cycle after ready.
REQ-038 req1 subtract a=0x40400000, b=0x3F800000 -> result 0x40000000, id 1; o_core_a/b stable across both EXEC cycles.
REQ-039 i_rst asserted mid-EXEC -> outputs 0 asynchronously; no response after release; next request accepted normally with requester 0 priority.
